// File: rtl/tpa_param_if.sv
// Register-port bundle between the on-chip configuration master and tpa_param.
// Four-phase request/acknowledge with command, address and data.
interface tpa_param_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic          cfg_req;
  logic          cfg_rdy;
  logic          cfg_cmd;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_wdata;
  logic [DW-1:0] cfg_rdata;

  modport master (output cfg_req, cfg_cmd, cfg_addr, cfg_wdata,
                  input  cfg_rdy, cfg_rdata);
  modport slave  (input  cfg_req, cfg_cmd, cfg_addr, cfg_wdata,
                  output cfg_rdy, cfg_rdata);
endinterface

// File: rtl/tpa_param.sv
// Two-port register array: serial two-wire slave plus four-phase register port, one shared space.
// Optional feature macro: TPA_PARITY_EN adds an even-parity bit to write and read frames.
module tpa_param #(
  parameter int AW   = 8,
  parameter int DW   = 16,
  parameter int PRIO = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCL,
  inout  wire        SDA,
  tpa_param_if.slave cfg,
  output logic       twp_err
);

  localparam int CNT_MAX = (AW > DW + 1) ? AW : DW + 1;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] ADDR_LAST = CW'(AW - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DW - 1);
`ifdef TPA_PARITY_EN
  localparam logic [CW-1:0] WDATA_LAST = CW'(DW);
`else
  localparam logic [CW-1:0] WDATA_LAST = CW'(DW - 1);
`endif

  typedef enum logic [3:0] {
    IDLE, MODE, ADDR, WDATA, COMMIT, TA1, TA2,
    DRV_HI, DRV_LO, RDATA, PAR, DRV_END
  } tw_state_e;

  typedef enum logic [1:0] {C_IDLE, C_WAIT, C_DONE} c_state_e;

  logic [DW-1:0] mem_q [2**AW];

  tw_state_e     tw_state_q, tw_state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] buf_q, buf_d;
`ifdef TPA_PARITY_EN
  logic          par_q, par_d;
`endif

  c_state_e      c_state_q, c_state_d;
  logic          cmd_q, cmd_d;
  logic [AW-1:0] caddr_q, caddr_d;
  logic [DW-1:0] cwdata_q, cwdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          sda_in, sda_oe, sda_o;
  logic [AW-1:0] addr_next;
  logic          tw_we, cfg_we, grant;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          unused_scl;

  // Frame timing comes from clk sampling of SDA alone; SCL is a reserved pin.
  assign unused_scl = SCL;
  assign sda_in     = SDA;
  assign SDA        = sda_oe ? sda_o : 1'bz;
  assign addr_next  = {sda_in, addr_q[AW-1:1]};

  // Two-wire frame FSM
  always_comb begin
    tw_state_d = tw_state_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    addr_d     = addr_q;
    buf_d      = buf_q;
`ifdef TPA_PARITY_EN
    par_d      = par_q;
`endif
    sda_oe     = 1'b0;
    sda_o      = 1'b0;
    tw_we      = 1'b0;
    twp_err    = 1'b0;
    case (tw_state_q)
      IDLE: if (!sda_in) tw_state_d = MODE;
      MODE: begin
        mode_d     = sda_in;
        cnt_d      = '0;
        tw_state_d = ADDR;
      end
      ADDR: begin
        addr_d = addr_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == ADDR_LAST) begin
          cnt_d = '0;
          if (mode_q) begin
            tw_state_d = WDATA;
          end else begin
            // Snapshot taken with the final address bit so later writes cannot leak in.
            buf_d      = mem_q[addr_next];
`ifdef TPA_PARITY_EN
            par_d      = ^mem_q[addr_next];
`endif
            tw_state_d = TA1;
          end
        end
      end
      WDATA: begin
`ifdef TPA_PARITY_EN
        if (cnt_q == CW'(DW)) par_d = sda_in;
        else                  buf_d = {sda_in, buf_q[DW-1:1]};
`else
        buf_d = {sda_in, buf_q[DW-1:1]};
`endif
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == WDATA_LAST) tw_state_d = COMMIT;
      end
      COMMIT: begin
`ifdef TPA_PARITY_EN
        if (^{buf_q, par_q}) twp_err = 1'b1;
        else                 tw_we   = 1'b1;
`else
        tw_we = 1'b1;
`endif
        tw_state_d = IDLE;
      end
      TA1: tw_state_d = TA2;
      TA2: tw_state_d = DRV_HI;
      DRV_HI: begin
        sda_oe     = 1'b1;
        sda_o      = 1'b1;
        tw_state_d = DRV_LO;
      end
      DRV_LO: begin
        sda_oe     = 1'b1;
        cnt_d      = '0;
        tw_state_d = RDATA;
      end
      RDATA: begin
        sda_oe = 1'b1;
        sda_o  = buf_q[0];
        buf_d  = {1'b0, buf_q[DW-1:1]};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == DATA_LAST) begin
`ifdef TPA_PARITY_EN
          tw_state_d = PAR;
`else
          tw_state_d = DRV_END;
`endif
        end
      end
      PAR: begin
        sda_oe     = 1'b1;
`ifdef TPA_PARITY_EN
        sda_o      = par_q;
`endif
        tw_state_d = DRV_END;
      end
      DRV_END: begin
        sda_oe     = 1'b1;
        tw_state_d = IDLE;
      end
      default: tw_state_d = IDLE;
    endcase
  end

  // Register-port FSM; grant keeps its writes off the two-wire commit cycle.
  assign grant = (PRIO == 0) ? ((tw_state_q == IDLE) && sda_in)
                             : (tw_state_q != COMMIT);

  always_comb begin
    c_state_d = c_state_q;
    cmd_d     = cmd_q;
    caddr_d   = caddr_q;
    cwdata_d  = cwdata_q;
    rdata_d   = rdata_q;
    cfg_we    = 1'b0;
    case (c_state_q)
      C_IDLE: begin
        if (cfg.cfg_req) begin
          cmd_d     = cfg.cfg_cmd;
          caddr_d   = cfg.cfg_addr;
          cwdata_d  = cfg.cfg_wdata;
          c_state_d = C_WAIT;
        end
      end
      C_WAIT: begin
        if (grant) begin
          if (cmd_q) cfg_we  = 1'b1;
          else       rdata_d = mem_q[caddr_q];
          c_state_d = C_DONE;
        end
      end
      C_DONE: if (!cfg.cfg_req) c_state_d = C_IDLE;
      default: c_state_d = C_IDLE;
    endcase
  end

  assign cfg.cfg_rdy   = (c_state_q == C_DONE);
  assign cfg.cfg_rdata = rdata_q;

  assign mem_we    = (tw_we | cfg_we) & ~reset;
  assign mem_waddr = tw_we ? addr_q : caddr_q;
  assign mem_wdata = tw_we ? buf_q  : cwdata_q;

  // State and visible outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      tw_state_q <= IDLE;
      c_state_q  <= C_IDLE;
      rdata_q    <= '0;
    end else begin
      tw_state_q <= tw_state_d;
      c_state_q  <= c_state_d;
      rdata_q    <= rdata_d;
    end
  end

  // Datapath registers and array
  always_ff @(posedge clk) begin
    cnt_q    <= cnt_d;
    mode_q   <= mode_d;
    addr_q   <= addr_d;
    buf_q    <= buf_d;
`ifdef TPA_PARITY_EN
    par_q    <= par_d;
`endif
    cmd_q    <= cmd_d;
    caddr_q  <= caddr_d;
    cwdata_q <= cwdata_d;
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_tpa_param.sv
// Directed bench for tpa_param: u0 built with PRIO=0, u1 with PRIO=1, both fed the same two-wire frames.
module tb_tpa_param;
  localparam int AW = 8;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scl = 1'b1;
  logic tb_en = 1'b1;
  logic tb_bit = 1'b1;
  logic err0, err1;
  wire  sda0, sda1;
  int   tests = 0;
  int   fails = 0;

  assign sda0 = tb_en ? tb_bit : 1'bz;
  assign sda1 = tb_en ? tb_bit : 1'bz;

  tpa_param_if #(.AW(AW), .DW(DW)) c0 ();
  tpa_param_if #(.AW(AW), .DW(DW)) c1 ();

  tpa_param #(.AW(AW), .DW(DW), .PRIO(0)) u0 (
    .clk(clk), .reset(reset), .SCL(scl), .SDA(sda0), .cfg(c0), .twp_err(err0));
  tpa_param #(.AW(AW), .DW(DW), .PRIO(1)) u1 (
    .clk(clk), .reset(reset), .SCL(scl), .SDA(sda1), .cfg(c1), .twp_err(err1));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tw_bit(input logic b);
    tb_bit = b;
    tick();
  endtask

  task automatic tw_head(input logic mode, input logic [AW-1:0] a);
    tw_bit(1'b0);
    tw_bit(mode);
    for (int i = 0; i < AW; i++) tw_bit(a[i]);
  endtask

  task automatic tw_data(input logic [DW-1:0] d, input int from, input int to);
    for (int i = from; i <= to; i++) tw_bit(d[i]);
  endtask

  // Idle register-port read with immediate grant: rdy and data at N+2.
  task automatic cfg_rd(input int which, input logic [AW-1:0] a, input logic [DW-1:0] exp,
                        input string tag);
    if (which == 0) begin c0.cfg_req = 1'b1; c0.cfg_cmd = 1'b0; c0.cfg_addr = a; end
    else            begin c1.cfg_req = 1'b1; c1.cfg_cmd = 1'b0; c1.cfg_addr = a; end
    tick();
    chk({tag, "_rdy_n1"}, (which == 0) ? c0.cfg_rdy : c1.cfg_rdy, 1'b0);
    tick();
    chk({tag, "_rdy_n2"}, (which == 0) ? c0.cfg_rdy : c1.cfg_rdy, 1'b1);
    chk({tag, "_rdata"}, (which == 0) ? c0.cfg_rdata : c1.cfg_rdata, exp);
    if (which == 0) c0.cfg_req = 1'b0;
    else            c1.cfg_req = 1'b0;
    tick();
    chk({tag, "_rdy_drop"}, (which == 0) ? c0.cfg_rdy : c1.cfg_rdy, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] rd0, rd1;
    logic          oe0, oe1;

    c0.cfg_req = 1'b0; c0.cfg_cmd = 1'b0; c0.cfg_addr = '0; c0.cfg_wdata = '0;
    c1.cfg_req = 1'b0; c1.cfg_cmd = 1'b0; c1.cfg_addr = '0; c1.cfg_wdata = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_rdy0", c0.cfg_rdy, 1'b0);
    chk("rst_rdy1", c1.cfg_rdy, 1'b0);
    chk("rst_rdata0", c0.cfg_rdata, 16'h0000);
    chk("rst_rdata1", c1.cfg_rdata, 16'h0000);
    chk("rst_oe0", u0.sda_oe, 1'b0);
    chk("rst_err0", err0, 1'b0);
    tick();

    // Two-wire write 0x12 = 0xA5C3, then register-port read right after commit
    d = 16'hA5C3;
    tw_head(1'b1, 8'h12);
    tw_data(d, 0, DW - 1);
`ifdef TPA_PARITY_EN
    tw_bit(^d);
`endif
    tb_bit = 1'b1;
    chk("commit_err0", err0, 1'b0);
    tick();
    cfg_rd(0, 8'h12, 16'hA5C3, "wr12_p0");
    cfg_rd(1, 8'h12, 16'hA5C3, "wr12_p1");

    // Two-wire read 0x12 on both; u1 gets a register write to 0x12 after the snapshot
    tw_head(1'b0, 8'h12);
    tb_en = 1'b0;
    c1.cfg_req = 1'b1; c1.cfg_cmd = 1'b1; c1.cfg_addr = 8'h12; c1.cfg_wdata = 16'hFFFF;
    chk("ta1_hiz0", u0.sda_oe, 1'b0);
    chk("ta1_hiz1", u1.sda_oe, 1'b0);
    tick();
    chk("ta2_hiz0", u0.sda_oe, 1'b0);
    chk("ta2_hiz1", u1.sda_oe, 1'b0);
    chk("snapwr_rdy_n1", c1.cfg_rdy, 1'b0);
    tick();
    chk("snapwr_rdy_n2", c1.cfg_rdy, 1'b1);
    c1.cfg_req = 1'b0;
    chk("drv_hi0", {u0.sda_oe, sda0}, 2'b11);
    chk("drv_hi1", {u1.sda_oe, sda1}, 2'b11);
    tick();
    chk("drv_lo0", {u0.sda_oe, sda0}, 2'b10);
    chk("drv_lo1", {u1.sda_oe, sda1}, 2'b10);
    chk("snapwr_rdy_drop", c1.cfg_rdy, 1'b0);
    oe0 = 1'b1; oe1 = 1'b1;
    for (int i = 0; i < DW; i++) begin
      tick();
      rd0[i] = sda0; rd1[i] = sda1;
      oe0 = oe0 & u0.sda_oe; oe1 = oe1 & u1.sda_oe;
    end
    chk("rdata_oe0", oe0, 1'b1);
    chk("rdata_oe1", oe1, 1'b1);
    chk("rd_bits0", rd0, 16'hA5C3);
    chk("rd_bits1_snapshot", rd1, 16'hA5C3);
`ifdef TPA_PARITY_EN
    tick();
    chk("rd_par0", {u0.sda_oe, sda0}, 2'b10);
`endif
    tick();
    chk("drv_end0", {u0.sda_oe, sda0}, 2'b10);
    chk("drv_end1", {u1.sda_oe, sda1}, 2'b10);
    tick();
    chk("release0", u0.sda_oe, 1'b0);
    chk("release1", u1.sda_oe, 1'b0);
    tb_en = 1'b1;
    tb_bit = 1'b1;
    tick();
    cfg_rd(1, 8'h12, 16'hFFFF, "after_snapwr_p1");

    // Two-wire write 0x40 = 0x2222 with a register write 0x40 = 0x1111 mid-frame
    d = 16'h2222;
    tw_head(1'b1, 8'h40);
    tw_data(d, 0, 3);
    c0.cfg_req = 1'b1; c0.cfg_cmd = 1'b1; c0.cfg_addr = 8'h40; c0.cfg_wdata = 16'h1111;
    c1.cfg_req = 1'b1; c1.cfg_cmd = 1'b1; c1.cfg_addr = 8'h40; c1.cfg_wdata = 16'h1111;
    tw_bit(d[4]);
    chk("mid_p1_rdy_n1", c1.cfg_rdy, 1'b0);
    tw_bit(d[5]);
    chk("mid_p1_rdy_n2", c1.cfg_rdy, 1'b1);
    chk("mid_p0_rdy_n2", c0.cfg_rdy, 1'b0);
    c1.cfg_req = 1'b0;
    tw_bit(d[6]);
    chk("mid_p1_rdy_drop", c1.cfg_rdy, 1'b0);
    tw_data(d, 7, DW - 1);
`ifdef TPA_PARITY_EN
    tw_bit(^d);
`endif
    tb_bit = 1'b1;
    chk("mid_p0_rdy_commit", c0.cfg_rdy, 1'b0);
    tick();
    chk("mid_p0_rdy_c1", c0.cfg_rdy, 1'b0);
    tick();
    chk("mid_p0_rdy_c2", c0.cfg_rdy, 1'b1);
    c0.cfg_req = 1'b0;
    tick();
    chk("mid_p0_rdy_drop", c0.cfg_rdy, 1'b0);
    cfg_rd(0, 8'h40, 16'h1111, "final40_p0");
    cfg_rd(1, 8'h40, 16'h2222, "final40_p1");

    // Reset in the middle of a write frame to 0x12 with a read pending on u0
    d = 16'h5A5A;
    tw_head(1'b1, 8'h12);
    c0.cfg_req = 1'b1; c0.cfg_cmd = 1'b0; c0.cfg_addr = 8'h12;
    tw_data(d, 0, 7);
    reset = 1'b1;
    c0.cfg_req = 1'b0;
    tb_bit = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_rdy0", c0.cfg_rdy, 1'b0);
    chk("midrst_rdy1", c1.cfg_rdy, 1'b0);
    chk("midrst_rdata0", c0.cfg_rdata, 16'h0000);
    chk("midrst_rdata1", c1.cfg_rdata, 16'h0000);
    chk("midrst_oe0", u0.sda_oe, 1'b0);
    chk("midrst_oe1", u1.sda_oe, 1'b0);
    tick();
    tick();
    cfg_rd(0, 8'h12, 16'hA5C3, "midrst_keep_p0");
    cfg_rd(1, 8'h12, 16'hFFFF, "midrst_keep_p1");

`ifdef TPA_PARITY_EN
    // Bad parity: error pulse on the commit cycle and no write
    d = 16'h0F0E;
    tw_head(1'b1, 8'h12);
    tw_data(d, 0, DW - 1);
    tw_bit(~(^d));
    tb_bit = 1'b1;
    chk("badpar_err0", err0, 1'b1);
    chk("badpar_err1", err1, 1'b1);
    tick();
    chk("badpar_err0_end", err0, 1'b0);
    cfg_rd(0, 8'h12, 16'hA5C3, "badpar_keep_p0");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
